// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Optional MDU_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic               is_div, neg_res, neg_rem, dz_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // product accumulator; low half holds raw dividend on divide-by-zero
    logic [2*WIDTH-1:0] mcand;   // shifted multiplicand; low half is the divisor for divides
    logic [WIDTH-1:0]   mplier;  // multiplier shift register, or dividend/quotient for divides
    logic [WIDTH-1:0]   rem;

    logic               accept, a_neg, b_neg, dz_in, mult_last, calc_last, ge;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_f, rem_f;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] mult_sum, prod;

    assign accept  = start && (state == IDLE || state == DONE);
    assign a_neg   = op[0] && a[WIDTH-1];
    assign b_neg   = op[0] && b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign dz_in   = op[1] && (b == '0);

    // Partial remainder stays below the divisor, so shifted < 2*divisor and diff's top bit is a clean borrow.
    assign shifted = {rem, mplier[WIDTH-1]};
    assign diff    = shifted - {1'b0, mcand[WIDTH-1:0]};
    assign ge      = !diff[WIDTH];

    assign mult_sum = acc + (mplier[0] ? mcand : '0);
`ifdef MDU_EARLY_OUT_EN
    assign mult_last = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(1));
`else
    assign mult_last = (cnt == CW'(1));
`endif
    assign calc_last = is_div ? (cnt == CW'(1)) : mult_last;

    assign prod  = neg_res ? -acc : acc;
    assign quo_f = neg_res ? -mplier : mplier;
    assign rem_f = neg_rem ? -rem : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        dz        = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = dz_in ? FIX : CALC;
            CALC: begin
                busy = 1'b1;
                if (calc_last) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                dz        = dz_q;
                state_nxt = start ? (dz_in ? FIX : CALC) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_q    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
        end else if (accept) begin
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz_q    <= dz_in;
            cnt     <= CW'(WIDTH);
            rem     <= '0;
            if (op[1]) begin
                mplier <= a_mag;
                mcand  <= {{WIDTH{1'b0}}, b_mag};
                acc    <= {{WIDTH{1'b0}}, a};
            end else begin
                mplier <= b_mag;
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                acc    <= '0;
            end
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (is_div) begin
                rem    <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                mplier <= {mplier[WIDTH-2:0], ge};
            end else begin
                acc    <= mult_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // Results land on the edge into DONE; MTHI/MTLO only when not busy, so a write in DONE wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (dz_q) begin
                hi <= acc[WIDTH-1:0];
                lo <= '1;
            end else if (is_div) begin
                hi <= rem_f;
                lo <= quo_f;
            end else begin
                {hi, lo} <= prod;
            end
        end else if (!busy) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized + directed bench for mdu_ctrl against a cycle-count/arithmetic reference model.
module tb_mdu_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    // Model: an accepted op is at step t (1 = first cycle after accept); result visible at t == lat.
    bit           m_act;
    int           m_t, m_lat;
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
    bit           r_dz;

    function automatic bit m_busy();
        return m_act && m_t >= 1 && m_t < m_lat;
    endfunction

    function automatic bit m_done();
        return m_act && m_t == m_lat;
    endfunction

    task automatic compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] rh, output logic [W-1:0] rl,
                           output bit rdz, output int lat);
        logic [63:0]  pu;
        longint       sx, sy, q, r;
        logic [W-1:0] mag;
        int           calc;
        rdz = 0;
        lat = W + 2;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        case (o)
            2'b00: pu = {32'b0, x} * {32'b0, y};
            2'b01: pu = 64'(sx * sy);
            default: pu = '0;
        endcase
        rh = pu[63:32];
        rl = pu[31:0];
        if (o[1]) begin
            if (y == '0) begin
                rh = x; rl = '1; rdz = 1; lat = 2;
            end else if (!o[0]) begin
                rl = x / y; rh = x % y;
            end else begin
                q = sx / sy; r = sx % sy;
                pu = 64'(q); rl = pu[31:0];
                pu = 64'(r); rh = pu[31:0];
            end
        end
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            mag  = (o[0] && y[W-1]) ? -y : y;
            calc = 1;
            for (int i = 0; i < W; i++) if (mag[i]) calc = i + 1;
            lat  = calc + 2;
        end
`endif
    endtask

    task automatic model_clear();
        m_act = 0; m_t = 0; m_lat = 0; m_hi = '0; m_lo = '0;
    endtask

    task automatic model_edge();
        bit bz;
        if (!rst) begin
            model_clear();
            return;
        end
        bz = m_busy();
        if (m_act) begin
            if (m_t == m_lat) m_act = 0;
            else begin
                m_t++;
                if (m_t == m_lat) begin m_hi = r_hi; m_lo = r_lo; end
            end
        end
        if (!bz) begin
            if (wr_hi) m_hi = wdata;
            if (wr_lo) m_lo = wdata;
        end
        if (start && !bz) begin
            compute(op, a, b, r_hi, r_lo, r_dz, m_lat);
            m_act = 1;
            m_t   = 1;
        end
    endtask

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        check("busy", W'(busy), W'(m_busy()));
        check("done", W'(done), W'(m_done()));
        check("dz",   W'(dz),   W'(m_done() && r_dz));
        check("hi",   hi, m_hi);
        check("lo",   lo, m_lo);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1; op = o; a = x; b = y;
        tick();
        start = 0;
    endtask

    // Called in cycle 1; returns the cycle in which done is seen and busy-cycle count.
    task automatic wait_done(input int cyc0, output int cyc, output int nbusy);
        cyc = cyc0;
        nbusy = 0;
        while (!done && cyc < 200) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    int cyc, nb, ndone;

    initial begin
        rst = 0; start = 0; wr_hi = 0; wr_lo = 0; op = 0; a = 0; b = 0; wdata = 0;
        model_clear();
        #12;
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        rst = 1;
        tick();

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, cyc, nb);
`ifndef MDU_EARLY_OUT_EN
        check("multu_cycle", cyc, 34);
        check("multu_busy_cnt", nb, 33);
`endif
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        tick();

        issue(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done(1, cyc, nb);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);

        issue(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done(1, cyc, nb);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(2'b10, 32'd7, 32'd0);
        wait_done(1, cyc, nb);
        check("dz_cycle", cyc, 2);
        check("dz_flag", W'(dz), 1);
        check("dz_hi", hi, 32'd7);
        check("dz_lo", lo, 32'hFFFFFFFF);

        issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, cyc, nb);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_dz", W'(dz), 0);
        tick();

        issue(2'b10, 32'd100, 32'd7);
        repeat (4) tick();
        start = 1; op = 2'b00; a = 2; b = 2; wr_hi = 1; wdata = 32'h1234;
        tick();
        start = 0; wr_hi = 0;
        wait_done(6, cyc, nb);
        check("ign_cycle", cyc, 34);
        check("ign_hi", hi, 32'd2);
        check("ign_lo", lo, 32'd14);
        tick();
        wr_lo = 1; wdata = 32'hABCD;
        tick();
        wr_lo = 0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_hi", hi, 32'd2);

        issue(2'b00, 32'h12345678, 32'h9ABCDEF1);
        repeat (9) tick();
        rst = 0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", W'(busy), 0);
        model_clear();
        repeat (2) tick();
        rst = 1;
        ndone = 0;
        repeat (40) begin tick(); if (done) ndone++; end
        check("abort_no_done", ndone, 0);

`ifdef MDU_EARLY_OUT_EN
        issue(2'b00, 32'd5, 32'd1);
        wait_done(1, cyc, nb);
        check("eo_cycle", cyc, 3);
        check("eo_lo", lo, 32'd5);
        check("eo_hi", hi, 32'd0);
        issue(2'b00, 32'd5, 32'd0);
        wait_done(1, cyc, nb);
        check("eo0_cycle", cyc, 3);
        check("eo0_lo", lo, 32'd0);
`endif

        repeat (4000) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'($urandom_range(0, 9));
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(0, 9));
                2: b = 32'hFFFFFFFF;
                3: b = 32'h80000000;
                default: b = $urandom;
            endcase
            wr_hi = ($urandom_range(0, 7) == 0);
            wr_lo = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            tick();
        end
        start = 0; wr_hi = 0; wr_lo = 0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide unit with its own sequencing FSM, HI/LO registers and a start/busy/done handshake toward the multicycle controller. It sits beside the ALU. The controller issues MULT/MULTU/DIV/DIVU with the GPR read values and waits on `busy`. It then reads `hi`/`lo` for MFHI/MFLO, and writes them through the MTHI/MTLO port.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; iteration count = `WIDTH`.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin operation; sampled only when `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `wr_hi`  in  1  MTHI strobe.
- `wr_lo`  in  1  MTLO strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress; controller must stall.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `dz`  out  1  one-cycle pulse with `done` when a DIV/DIVU had `b`=0.
- `hi`  out  WIDTH  HI register: product upper half / remainder.
- `lo`  out  WIDTH  LO register: product lower half / quotient.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. While `rst`=0: state=IDLE, `hi`=`lo`=0, `busy`=`done`=`dz`=0, and the iteration counter and work registers are 0.
- IDLE, or DONE, with `start`=1:
  - Capture `op`.
  - For signed ops, capture the magnitudes of `a` and `b` and record the result signs.
  - Load the counter with `WIDTH`.
  - Go to CALC. If the op is a divide and `b`=0, go to FIX instead.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- CALC exit: after `WIDTH` cycles, go to FIX.
- FIX:
  - Product: negate the 2·WIDTH result if the operand signs differ.
  - Quotient: negate if the signs differ. Remainder: takes the sign of the dividend.
  - Go to DONE.
- DONE:
  - `hi`/`lo` are written on the edge entering DONE. `done`=1 for this cycle. Next state is IDLE, or CALC/FIX if `start`=1.
- Divide by zero: `hi`=`a`, `lo`={WIDTH{1}}, `dz`=1 in DONE. The rule is identical for DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0, `dz`=0. No trap is raised.
- `start` while `busy`=1 is ignored.
- `wr_hi`/`wr_lo` while `busy`=1 are ignored. Otherwise the write lands on the next edge.
- `wr_*` in the same cycle as an accepted `start`: the write lands, and the result later overwrites it.
- A `wr_*` in DONE is applied after the result: the write wins.
- `rst` asserted mid-operation aborts immediately. All outputs return to reset values, and no `done` is produced.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled.
- Full-length operation (MULT/MULTU without the Configuration macro, and every non-zero-divisor DIV/DIVU):
  - CALC occupies cycles 1..WIDTH.
  - FIX occupies cycle WIDTH+1.
  - DONE occupies cycle WIDTH+2.
- Divide by zero: FIX in cycle 1, DONE in cycle 2.
- `busy`=1 in CALC and FIX only. It is 0 in IDLE and DONE, so back-to-back issue from DONE is allowed.
- `hi`/`lo` are registered outputs that change only on entering DONE or on an accepted `wr_*`. They are stable while `busy`=1.
- `done` and `dz` are registered state decodes with no combinational path from inputs.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - MULT/MULTU leave CALC as soon as the remaining multiplier shift register is zero.
  - CALC cycles = 1 + index of the highest set bit of |b|, minimum 1.
  - `b`=0 costs 1 CALC cycle.
  - Divides are unchanged.
- `MDU_EARLY_OUT_EN` undefined: every MULT/MULTU takes exactly `WIDTH` CALC cycles.
- Results are identical in both builds.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (macro off) -> `done` in cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high cycles 1–33.
- MULT 0xFFFFFFFD × 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV 0xFFFFFFF9 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 7 / 0 -> `done` and `dz` in cycle 2, `hi`=7, `lo`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Accept DIVU 100 / 7. Assert `start` (MULTU 2 × 2) and `wr_hi` (0x1234) in cycle 5. -> Both are ignored; `hi`=2, `lo`=14 in cycle 34. Then MTLO 0xABCD in IDLE -> `lo`=0xABCD next cycle, `hi` unchanged.
- Drive `rst` low in cycle 10 of a MULTU. -> `hi`=`lo`=0 and `busy`=0 immediately; no `done` pulse after release.
- With `MDU_EARLY_OUT_EN`: MULTU 5 × 1 -> `done` in cycle 3, `lo`=5, `hi`=0. MULTU 5 × 0 -> `done` in cycle 3, `lo`=0.
